seg_scan_ctrl: RTL

- Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one BCD-to-segment decoder.
- Holds the displayed BCD value and walks the digit enables one at a time, presenting each digit's nibble to the shared decoder.
- Inserts an all-off guard interval between digits to suppress ghosting.
- Accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits sharing one decoder.
// Walks the digit enables with guard blanking and commits new display values only at frame wrap.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit LZB_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  output logic                    upd_ready,
  input  logic                    blank_all,
  output logic [3:0]              dec_in,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_done
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    wrap;
  logic                    pending;
  logic                    transfer;
  logic [4*NUM_DIGITS-1:0] active, active_nxt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] shown;
  logic [3:0]              dec_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  assign upd_ready = !pending;
  assign transfer  = upd_valid && !pending;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    wrap      = 1'b0;
    case (state)
      BLANK: begin
        if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt   = '0;
          wrap      = (idx == IDX_LAST);
          idx_nxt   = wrap ? '0 : idx + 1'b1;
          state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Outputs are derived from next-state values so they change on the edge that enters a state,
  // and a commit on the wrap edge is already visible when digit 0 lights.
  always_comb begin
    active_nxt = (wrap && pending) ? shadow : active;
    shown      = active_nxt;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (LZB_EN && ((active_nxt >> (4 * k)) == '0)) begin
        shown[4*k +: 4] = 4'hF;
      end
    end
    dec_nxt = 4'hF;
    sel_nxt = '1;
    if (state_nxt == SHOW && !blank_all) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_nxt == IW'(k)) begin
          dec_nxt    = shown[4*k +: 4];
          sel_nxt[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      active     <= '1;
      shadow     <= '0;
      pending    <= 1'b0;
      dec_in     <= 4'hF;
      dig_sel_n  <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      active     <= active_nxt;
      dec_in     <= dec_nxt;
      dig_sel_n  <= sel_nxt;
      frame_done <= wrap;
      // Commit and transfer are mutually exclusive because transfer needs pending low.
      if (wrap && pending) begin
        pending <= 1'b0;
      end else if (transfer) begin
        shadow  <= upd_data;
        pending <= 1'b1;
      end
    end
  end

endmodule
